regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of registers (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port write_regf_en, input, 1, write strobe.
REQ-008 SHALL have port addr_rd, input, AW, write address.
REQ-009 SHALL have port rd_value, input, XLEN, write data.
REQ-010 SHALL have ports addr_rs1 and addr_rs2, input, AW, read addresses.
REQ-011 SHALL have ports rs1_value and rs2_value, output, XLEN, read data.
REQ-012 SHALL have ports rs1_busy and rs2_busy, output, 1, addressed register has a pending write.
REQ-013 SHALL have port alloc_en, input, 1, request to mark a register pending (long-latency op issued).
REQ-014 SHALL have port alloc_addr, input, AW, register to mark pending.
REQ-015 SHALL have port alloc_ok, output, 1, combinational, alloc request accepted this cycle.
REQ-016 SHALL have port dbg_addr, input, AW, debug read address.
REQ-017 SHALL have port dbg_value, output, XLEN, debug read data, no bypass.
REQ-018 SHALL have port busy_cnt, output, AW+1, number of pending registers.

Function
REQ-019 SHALL read asynchronously: rsN_value = regs[addr_rsN]; dbg_value = regs[dbg_addr].
REQ-020 SHALL write regs[addr_rd] <= rd_value at the clock edge when write_regf_en=1 and rst=0.
REQ-021 SHALL, with ZERO_REG=1, ignore writes and allocs to register 0; reads of register 0 return 0; rsN_busy for register 0 is 0.
REQ-022 SHALL, with BYPASS=1, drive rsN_value = rd_value when write_regf_en=1 and addr_rd==addr_rsN (excluding register 0 when ZERO_REG=1); with BYPASS=0 return stored value.
REQ-023 SHALL keep one busy bit per register; a write clears the addressed busy bit at the edge.
REQ-024 SHALL accept an alloc (alloc_ok=1) when alloc_en=1 and the target busy bit is 0, or its pending write completes this cycle, or target is register 0 with ZERO_REG=1.
REQ-025 SHALL reject an alloc (alloc_ok=0, no state change) when the target is busy and not being written this cycle; alloc_ok=0 whenever alloc_en=0.
REQ-026 SHALL, on simultaneous write and accepted alloc to the same register, store rd_value and leave the busy bit set (set wins).
REQ-027 SHALL drive rsN_busy = busy[addr_rsN], forced 0 when the same register is written this cycle and BYPASS=1.
REQ-028 SHALL allow writes to non-busy registers (plain single-cycle writes) with no busy effect.
REQ-029 SHALL keep busy_cnt equal to the popcount of busy bits, updated in the same edge (+1, -1, or net 0 for simultaneous set and clear on different registers).
REQ-030 SHALL never exceed NREGS-ZERO_REG in busy_cnt.

Reset
REQ-031 SHALL, when rst=1 at an edge, clear all registers to 0, all busy bits, and busy_cnt to 0, overriding any write or alloc in that cycle.
REQ-032 SHALL drive alloc_ok=0 while rst=1; rsN_value, rsN_busy and dbg_value reflect current state combinationally.

Verification
REQ-033 SHALL pass: reset, write x5=0xDEADBEEF, next cycle read rs1=5 -> 0xDEADBEEF; write x0=0x1234 -> read x0=0.
REQ-034 SHALL pass: write x7=0xA5A5A5A5 with addr_rs2=7 same cycle -> rs2_value=0xA5A5A5A5 (BYPASS=1), old value (BYPASS=0); dbg_value shows old value that cycle.
REQ-035 SHALL pass: alloc x3 -> alloc_ok=1, next cycle rs1_busy=1, busy_cnt=1; second alloc x3 -> alloc_ok=0, busy_cnt=1; write x3=0x55 -> busy cleared, busy_cnt=0.
REQ-036 SHALL pass: x4 busy; same cycle write x4=0x99 and alloc x4 -> alloc_ok=1, x4=0x99, busy stays 1, busy_cnt unchanged.
REQ-037 SHALL pass: alloc x1, x2, x9 on consecutive cycles, then rst=1 concurrent with write x1 -> all regs 0, busy_cnt=0, rs1_busy=0.
REQ-038 SHALL pass: parameter sweep XLEN=64, NREGS=16, ZERO_REG=0 -> register 0 writable/allocatable, busy_cnt reaches 16 after 16 allocs.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Register file with per-register busy scoreboard, optional
//                hardwired zero register and same-cycle write forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_regf_en,
  input  logic [$clog2(NREGS)-1:0]   addr_rd,
  input  logic [XLEN-1:0]            rd_value,
  input  logic [$clog2(NREGS)-1:0]   addr_rs1,
  input  logic [$clog2(NREGS)-1:0]   addr_rs2,
  output logic [XLEN-1:0]            rs1_value,
  output logic [XLEN-1:0]            rs2_value,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  input  logic                       alloc_en,
  input  logic [$clog2(NREGS)-1:0]   alloc_addr,
  output logic                       alloc_ok,
  input  logic [$clog2(NREGS)-1:0]   dbg_addr,
  output logic [XLEN-1:0]            dbg_value,
  output logic [$clog2(NREGS):0]     busy_cnt
);

  localparam int c_aw = $clog2(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_busy [NREGS];
  logic [c_aw:0]   r_busy_cnt;

  logic            w_rd_zero;
  logic            w_wr;
  logic            w_alloc_zero;
  logic            w_alloc_ok;
  logic            w_set;
  logic            w_inc;
  logic            w_dec;
  logic [c_aw-1:0] w_rs_addr  [2];
  logic [XLEN-1:0] w_rs_value [2];
  logic            w_rs_busy  [2];

  assign w_rd_zero    = (ZERO_REG != 0) && (addr_rd == '0);
  assign w_wr         = write_regf_en && !w_rd_zero;
  assign w_alloc_zero = (ZERO_REG != 0) && (alloc_addr == '0);

  // A busy target is still accepted when its pending write lands this cycle.
  assign w_alloc_ok = alloc_en && !rst &&
                      (!r_busy[alloc_addr] ||
                       (w_wr && (addr_rd == alloc_addr)) ||
                       w_alloc_zero);
  assign w_set      = w_alloc_ok && !w_alloc_zero;

  // Count moves only on real 0->1 and 1->0 transitions; set beats clear.
  assign w_inc = w_set && !r_busy[alloc_addr];
  assign w_dec = w_wr && r_busy[addr_rd] && !(w_set && (alloc_addr == addr_rd));

  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
      localparam logic [c_aw-1:0] c_idx = c_aw'(i);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_regs[i] <= '0;
        end else if (w_wr && (addr_rd == c_idx)) begin
          r_regs[i] <= rd_value;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_busy[i] <= 1'b0;
        end else if (w_set && (alloc_addr == c_idx)) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr && (addr_rd == c_idx)) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt + {{c_aw{1'b0}}, w_inc} - {{c_aw{1'b0}}, w_dec};
    end
  end

  assign w_rs_addr[0] = addr_rs1;
  assign w_rs_addr[1] = addr_rs2;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      always_comb begin
        w_rs_value[p] = r_regs[w_rs_addr[p]];
        w_rs_busy[p]  = r_busy[w_rs_addr[p]];
        if ((ZERO_REG != 0) && (w_rs_addr[p] == '0)) begin
          w_rs_value[p] = '0;
          w_rs_busy[p]  = 1'b0;
        end
        if ((BYPASS != 0) && w_wr && (addr_rd == w_rs_addr[p])) begin
          w_rs_value[p] = rd_value;
          w_rs_busy[p]  = 1'b0;
        end
      end
    end
  endgenerate

  assign rs1_value = w_rs_value[0];
  assign rs2_value = w_rs_value[1];
  assign rs1_busy  = w_rs_busy[0];
  assign rs2_busy  = w_rs_busy[1];
  assign alloc_ok  = w_alloc_ok;
  assign busy_cnt  = r_busy_cnt;
  assign dbg_value = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Directed self-checking bench for regfile_sb (default,
//                no-bypass and 64-bit/16-register/no-zero-register builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_regf_en;
  logic [4:0]  addr_rd;
  logic [31:0] rd_value;
  logic [4:0]  addr_rs1, addr_rs2;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [4:0]  dbg_addr;

  logic [31:0] a_rs1_value, a_rs2_value, a_dbg_value;
  logic        a_rs1_busy, a_rs2_busy, a_alloc_ok;
  logic [5:0]  a_busy_cnt;
  logic [31:0] b_rs1_value, b_rs2_value, b_dbg_value;
  logic        b_rs1_busy, b_rs2_busy, b_alloc_ok;
  logic [5:0]  b_busy_cnt;

  logic        c_rst;
  logic        c_we;
  logic [3:0]  c_addr_rd, c_addr_rs1, c_addr_rs2, c_alloc_addr, c_dbg_addr;
  logic [63:0] c_rd_value;
  logic        c_alloc_en;
  logic [63:0] c_rs1_value, c_rs2_value, c_dbg_value;
  logic        c_rs1_busy, c_rs2_busy, c_alloc_ok;
  logic [4:0]  c_busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_sb u_dut_a (
    .clk(clk), .rst(rst), .write_regf_en(write_regf_en), .addr_rd(addr_rd),
    .rd_value(rd_value), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .rs1_value(a_rs1_value), .rs2_value(a_rs2_value),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(a_alloc_ok),
    .dbg_addr(dbg_addr), .dbg_value(a_dbg_value), .busy_cnt(a_busy_cnt)
  );

  regfile_sb #(.BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .write_regf_en(write_regf_en), .addr_rd(addr_rd),
    .rd_value(rd_value), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .rs1_value(b_rs1_value), .rs2_value(b_rs2_value),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(b_alloc_ok),
    .dbg_addr(dbg_addr), .dbg_value(b_dbg_value), .busy_cnt(b_busy_cnt)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(0)) u_dut_c (
    .clk(clk), .rst(c_rst), .write_regf_en(c_we), .addr_rd(c_addr_rd),
    .rd_value(c_rd_value), .addr_rs1(c_addr_rs1), .addr_rs2(c_addr_rs2),
    .rs1_value(c_rs1_value), .rs2_value(c_rs2_value),
    .rs1_busy(c_rs1_busy), .rs2_busy(c_rs2_busy),
    .alloc_en(c_alloc_en), .alloc_addr(c_alloc_addr), .alloc_ok(c_alloc_ok),
    .dbg_addr(c_dbg_addr), .dbg_value(c_dbg_value), .busy_cnt(c_busy_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1; write_regf_en = 1'b0; addr_rd = '0; rd_value = '0;
    addr_rs1 = '0; addr_rs2 = '0; alloc_en = 1'b0; alloc_addr = '0; dbg_addr = '0;
    c_rst = 1'b1; c_we = 1'b0; c_addr_rd = '0; c_rd_value = '0; c_addr_rs1 = '0;
    c_addr_rs2 = '0; c_alloc_en = 1'b0; c_alloc_addr = '0; c_dbg_addr = '0;

    cyc();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    settle();
    check("alloc_ok_in_rst", {63'd0, a_alloc_ok}, 64'd0);
    cyc();
    rst = 1'b0; c_rst = 1'b0; alloc_en = 1'b0;
    addr_rs1 = 5'd5; addr_rs2 = 5'd3;
    settle();
    check("rst_busy_cnt", {58'd0, a_busy_cnt}, 64'd0);
    check("rst_rs1_value", {32'd0, a_rs1_value}, 64'd0);
    check("rst_rs2_busy", {63'd0, a_rs2_busy}, 64'd0);

    // Plain write then read, and the zero register.
    write_regf_en = 1'b1; addr_rd = 5'd5; rd_value = 32'hDEADBEEF;
    cyc();
    write_regf_en = 1'b0;
    settle();
    check("x5_read", {32'd0, a_rs1_value}, 64'hDEADBEEF);
    check("x5_read_nobyp", {32'd0, b_rs1_value}, 64'hDEADBEEF);
    write_regf_en = 1'b1; addr_rd = 5'd0; rd_value = 32'h1234;
    cyc();
    write_regf_en = 1'b0; addr_rs1 = 5'd0; dbg_addr = 5'd0;
    settle();
    check("x0_read", {32'd0, a_rs1_value}, 64'd0);
    check("x0_dbg", {32'd0, a_dbg_value}, 64'd0);

    // Same-cycle forwarding.
    write_regf_en = 1'b1; addr_rd = 5'd7; rd_value = 32'hA5A5A5A5;
    addr_rs2 = 5'd7; dbg_addr = 5'd7;
    settle();
    check("byp_rs2", {32'd0, a_rs2_value}, 64'hA5A5A5A5);
    check("nobyp_rs2_old", {32'd0, b_rs2_value}, 64'd0);
    check("dbg_old", {32'd0, a_dbg_value}, 64'd0);
    cyc();
    write_regf_en = 1'b0;
    settle();
    check("nobyp_rs2_new", {32'd0, b_rs2_value}, 64'hA5A5A5A5);

    // Alloc / reject / clear on x3.
    alloc_en = 1'b1; alloc_addr = 5'd3;
    settle();
    check("alloc3_ok", {63'd0, a_alloc_ok}, 64'd1);
    cyc();
    alloc_en = 1'b0; addr_rs1 = 5'd3;
    settle();
    check("x3_busy", {63'd0, a_rs1_busy}, 64'd1);
    check("cnt_1", {58'd0, a_busy_cnt}, 64'd1);
    alloc_en = 1'b1;
    settle();
    check("alloc3_reject", {63'd0, a_alloc_ok}, 64'd0);
    cyc();
    alloc_en = 1'b0;
    settle();
    check("cnt_after_reject", {58'd0, a_busy_cnt}, 64'd1);
    write_regf_en = 1'b1; addr_rd = 5'd3; rd_value = 32'h55;
    settle();
    check("byp_busy_fwd", {63'd0, a_rs1_busy}, 64'd0);
    check("nobyp_busy", {63'd0, b_rs1_busy}, 64'd1);
    cyc();
    write_regf_en = 1'b0;
    settle();
    check("x3_cleared", {63'd0, a_rs1_busy}, 64'd0);
    check("cnt_0", {58'd0, a_busy_cnt}, 64'd0);
    check("x3_value", {32'd0, a_rs1_value}, 64'h55);

    // Write and alloc of a busy register in the same cycle: set wins.
    alloc_en = 1'b1; alloc_addr = 5'd4;
    cyc();
    alloc_en = 1'b1; alloc_addr = 5'd4;
    write_regf_en = 1'b1; addr_rd = 5'd4; rd_value = 32'h99;
    settle();
    check("x4_realloc_ok", {63'd0, a_alloc_ok}, 64'd1);
    cyc();
    alloc_en = 1'b0; write_regf_en = 1'b0; addr_rs1 = 5'd4;
    settle();
    check("x4_value", {32'd0, a_rs1_value}, 64'h99);
    check("x4_still_busy", {63'd0, a_rs1_busy}, 64'd1);
    check("cnt_x4", {58'd0, a_busy_cnt}, 64'd1);

    // Set x6 while clearing x4: net zero.
    alloc_en = 1'b1; alloc_addr = 5'd6;
    write_regf_en = 1'b1; addr_rd = 5'd4; rd_value = 32'h77;
    cyc();
    write_regf_en = 1'b0; alloc_addr = 5'd0;
    settle();
    check("cnt_net0", {58'd0, a_busy_cnt}, 64'd1);
    check("alloc_x0_ok", {63'd0, a_alloc_ok}, 64'd1);
    cyc();
    alloc_en = 1'b0;
    settle();
    check("cnt_after_x0", {58'd0, a_busy_cnt}, 64'd1);

    // Several allocs then reset overriding a write.
    alloc_en = 1'b1; alloc_addr = 5'd1; cyc();
    alloc_addr = 5'd2; cyc();
    alloc_addr = 5'd9; cyc();
    alloc_en = 1'b0;
    settle();
    check("cnt_4", {58'd0, a_busy_cnt}, 64'd4);
    rst = 1'b1; write_regf_en = 1'b1; addr_rd = 5'd1; rd_value = 32'hFFFF;
    cyc();
    rst = 1'b0; write_regf_en = 1'b0; addr_rs1 = 5'd1; dbg_addr = 5'd5;
    settle();
    check("rst_x1_value", {32'd0, a_rs1_value}, 64'd0);
    check("rst_x1_busy", {63'd0, a_rs1_busy}, 64'd0);
    check("rst_cnt", {58'd0, a_busy_cnt}, 64'd0);
    check("rst_x5_dbg", {32'd0, a_dbg_value}, 64'd0);

    // 64-bit, 16 registers, register 0 is ordinary.
    c_we = 1'b1; c_addr_rd = 4'd0; c_rd_value = 64'h1122334455667788;
    cyc();
    c_we = 1'b0; c_addr_rs1 = 4'd0;
    settle();
    check("c_x0_value", c_rs1_value, 64'h1122334455667788);
    for (int i = 0; i < 16; i++) begin
      c_alloc_en = 1'b1; c_alloc_addr = 4'(i);
      settle();
      check("c_alloc_ok", {63'd0, c_alloc_ok}, 64'd1);
      cyc();
    end
    c_alloc_en = 1'b1; c_alloc_addr = 4'd5;
    settle();
    check("c_cnt_16", {59'd0, c_busy_cnt}, 64'd16);
    check("c_x0_busy", {63'd0, c_rs1_busy}, 64'd1);
    check("c_realloc_reject", {63'd0, c_alloc_ok}, 64'd0);
    cyc();
    c_alloc_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
